uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame_if.sv | 24 ++
 rtl/uart_tx_frame.sv | 159 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Load/commit handshake between a byte producer and uart_tx_frame.
// The producer drives data, valid and send; the transmitter returns ready.
interface uart_tx_frame_if #(
    parameter int unsigned N_DATA_BITS = 8
);
    logic [N_DATA_BITS-1:0] i_data;
    logic                   i_data_valid;
    logic                   o_data_ready;
    logic                   i_send;

    modport master (
        output i_data,
        output i_data_valid,
        output i_send,
        input  o_data_ready
    );

    modport slave (
        input  i_data,
        input  i_data_valid,
        input  i_send,
        output o_data_ready
    );
endinterface

// File: rtl/uart_tx_frame.sv
// Buffered UART frame transmitter: load up to DEPTH bytes, commit, serialise on o_tx.
// Define UART_TX_CHECKSUM_EN to append the modulo-2^N byte sum as a trailing character.
module uart_tx_frame #(
    parameter int unsigned N_DATA_BITS = 8,
    parameter int unsigned DEPTH       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_en,
    uart_tx_frame_if.slave         bus,
    output logic                   o_busy,
    output logic                   o_tx,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [N_DATA_BITS-1:0] o_checksum
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;

`ifdef UART_TX_CHECKSUM_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_CSUM_SEL} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t                 r_state, w_state_nxt;
    logic                   r_tx, w_tx_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_ready, w_ready_nxt;
    logic [CW-1:0]          r_count, w_count_nxt;
    logic [N_DATA_BITS-1:0] r_checksum, w_sum_nxt;
    logic [CW-1:0]          r_rd_idx, w_rd_nxt;
    logic [BW-1:0]          r_bit, w_bit_nxt;
    logic [N_DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                   w_load;
    logic                   w_more;
    logic [N_DATA_BITS-1:0] r_mem [DEPTH];
`ifdef UART_TX_CHECKSUM_EN
    logic                   r_csum_done, w_csum_done_nxt;
`endif

    // STOP doubles as the "line high, next strobe may start a character" state,
    // so a fresh commit enters STOP and the first strobe drives the start bit.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_count_nxt = r_count;
        w_sum_nxt   = r_checksum;
        w_rd_nxt    = r_rd_idx;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_more      = (r_rd_idx != r_count);
`ifdef UART_TX_CHECKSUM_EN
        w_csum_done_nxt = r_csum_done;
`endif
        case (r_state)
            ST_IDLE: begin
                w_load = bus.i_data_valid && r_ready;
                if (w_load) begin
                    w_count_nxt = r_count + CW'(1);
                    w_sum_nxt   = r_checksum + bus.i_data;
                end
                if (bus.i_send && ((r_count != '0) || w_load)) begin
                    w_state_nxt = ST_STOP;
                    w_rd_nxt    = '0;
`ifdef UART_TX_CHECKSUM_EN
                    w_csum_done_nxt = 1'b0;
`endif
                end
            end
            ST_STOP: if (i_en) begin
                if (w_more) begin
                    w_shift_nxt = r_mem[r_rd_idx[AW-1:0]];
                    w_rd_nxt    = r_rd_idx + CW'(1);
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_START;
                end else begin
                    w_tx_nxt    = 1'b1;
                    w_count_nxt = '0;
                    w_sum_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: if (i_en) begin
                w_tx_nxt    = r_shift[0];
                w_shift_nxt = {1'b0, r_shift[N_DATA_BITS-1:1]};
                w_bit_nxt   = '0;
                w_state_nxt = ST_DATA;
            end
            ST_DATA: if (i_en) begin
                if (r_bit == BW'(N_DATA_BITS - 1)) begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = ST_STOP;
`ifdef UART_TX_CHECKSUM_EN
                    if (!w_more && !r_csum_done) w_state_nxt = ST_CSUM_SEL;
`endif
                end else begin
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[N_DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit + BW'(1);
                end
            end
`ifdef UART_TX_CHECKSUM_EN
            // Stop bit of the last buffered byte; next strobe starts the checksum character.
            ST_CSUM_SEL: if (i_en) begin
                w_shift_nxt     = r_checksum;
                w_tx_nxt        = 1'b0;
                w_csum_done_nxt = 1'b1;
                w_state_nxt     = ST_START;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_ready_nxt = (w_state_nxt == ST_IDLE) && (w_count_nxt < CW'(DEPTH));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_count    <= '0;
            r_checksum <= '0;
            r_rd_idx   <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
`ifdef UART_TX_CHECKSUM_EN
            r_csum_done <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_ready    <= w_ready_nxt;
            r_count    <= w_count_nxt;
            r_checksum <= w_sum_nxt;
            r_rd_idx   <= w_rd_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
`ifdef UART_TX_CHECKSUM_EN
            r_csum_done <= w_csum_done_nxt;
`endif
        end
    end

    // Frame buffer; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_load) r_mem[r_count[AW-1:0]] <= bus.i_data;
    end

    assign bus.o_data_ready = r_ready;
    assign o_busy           = r_busy;
    assign o_tx             = r_tx;
    assign o_count          = r_count;
    assign o_checksum       = r_checksum;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a line monitor decodes characters and
// compares them against bytes queued by the stimulus tasks.
module tb_uart_tx_frame;
`ifdef UART_TX_CHECKSUM_EN
    localparam int NCH = 2;
`else
    localparam int NCH = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       i_en;
    logic       o_busy;
    logic       o_tx;
    logic [4:0] o_count;
    logic [7:0] o_checksum;

    uart_tx_frame_if #(.N_DATA_BITS(8)) bus_if ();

    uart_tx_frame #(.N_DATA_BITS(8), .DEPTH(16)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_en      (i_en),
        .bus       (bus_if),
        .o_busy    (o_busy),
        .o_tx      (o_tx),
        .o_count   (o_count),
        .o_checksum(o_checksum)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         m_count = 0;
    logic [7:0] m_sum = 8'h00;
    int         en_period = 1;
    int         en_cnt = 0;
    int         mon_chars = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        i_en = 1'b0;
        forever begin
            @(negedge clk);
            if (en_cnt >= en_period - 1) begin
                en_cnt = 0;
                i_en   = 1'b1;
            end else begin
                en_cnt++;
                i_en = 1'b0;
            end
        end
    end

    // Line monitor: decodes characters at strobe edges, checks o_tx is quiet between strobes.
    initial begin
        int         mstate;
        int         mbit;
        logic [7:0] mbyte;
        logic [7:0] exp;
        logic       last_tx;
        mstate = 0; mbit = 0; mbyte = 8'h00; last_tx = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                mstate = 0;
            end else if (!i_en) begin
                n_vec++;
                if (o_tx !== last_tx) begin
                    n_err++;
                    $display("FAIL tx_quiet: o_tx=%b changed without strobe, required %b", o_tx, last_tx);
                end
            end else begin
                case (mstate)
                    0: if (o_tx == 1'b0) begin mstate = 1; mbit = 0; end
                    1: begin
                        mbyte[mbit] = o_tx;
                        mbit++;
                        if (mbit == 8) mstate = 2;
                    end
                    default: begin
                        mstate = 0;
                        mon_chars++;
                        n_vec++;
                        if (o_tx !== 1'b1) begin
                            n_err++;
                            $display("FAIL stop_bit: o_tx=%b required 1", o_tx);
                        end
                        n_vec++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL char_unexpected: got 0x%02h, required no character", mbyte);
                        end else begin
                            exp = exp_q.pop_front();
                            if (mbyte !== exp) begin
                                n_err++;
                                $display("FAIL char_data: got 0x%02h required 0x%02h", mbyte, exp);
                            end
                        end
                    end
                endcase
            end
            last_tx = o_tx;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one load at the current negedge; caller deasserts valid afterwards.
    task automatic put(input logic [7:0] b);
        bus_if.i_data       = b;
        bus_if.i_data_valid = 1'b1;
        if (m_count < 16) begin
            exp_q.push_back(b);
            m_count++;
            m_sum = m_sum + b;
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input string name);
        bus_if.i_send = 1'b1;
`ifdef UART_TX_CHECKSUM_EN
        if (m_count > 0) exp_q.push_back(m_sum);
`endif
        @(negedge clk);
        bus_if.i_send = 1'b0;
        n_vec++;
        if (o_busy !== 1'b1 || bus_if.o_data_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s_commit: busy=%b ready=%b required busy=1 ready=0", name, o_busy, bus_if.o_data_ready);
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (o_busy === 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, o_busy, cyc);
        end
        n_vec++;
        if (o_count !== 5'd0 || o_checksum !== 8'h00 || bus_if.o_data_ready !== 1'b1 || o_tx !== 1'b1) begin
            n_err++;
            $display("FAIL %s_idle: count=%0d csum=0x%02h ready=%b tx=%b required 0/0x00/1/1",
                     name, o_count, o_checksum, bus_if.o_data_ready, o_tx);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_pending: %0d characters not transmitted, required 0", name, exp_q.size());
        end
        exp_q.delete();
        m_count = 0;
        m_sum   = 8'h00;
    endtask

    task automatic wait_tx_low(input string name);
        int cyc;
        cyc = 0;
        while (o_tx !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (o_tx !== 1'b0) begin
            n_err++;
            $display("FAIL %s_start: no start bit within %0d cycles, tx=%b required 0", name, cyc, o_tx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_count !== 5'd0 || o_checksum !== 8'h00 ||
            bus_if.o_data_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: tx=%b busy=%b count=%0d csum=0x%02h ready=%b required 1/0/0/0x00/1",
                     o_tx, o_busy, o_count, o_checksum, bus_if.o_data_ready);
        end
    endtask

    task automatic test_bit_timing();
        int run;
        int total;
        logic prev;
        en_period = 64;
        @(negedge clk);
        put(8'h55);
        bus_if.i_data_valid = 1'b0;
        n_vec++;
        if (o_count !== 5'd1 || o_checksum !== 8'h55) begin
            n_err++;
            $display("FAIL timing_load: count=%0d csum=0x%02h required 1/0x55", o_count, o_checksum);
        end
        send_frame("timing");
        wait_tx_low("timing");
        total = 0;
        for (int k = 0; k < 9; k++) begin
            prev = o_tx;
            run  = 0;
            while (o_tx === prev && run < 200) begin
                @(negedge clk);
                run++;
            end
            total += run;
            n_vec++;
            if (run != 64 || o_tx !== ~prev) begin
                n_err++;
                $display("FAIL timing_bit%0d: held %0d cycles then tx=%b, required 64 then %b", k, run, o_tx, ~prev);
            end
        end
        run = 0;
        while (o_busy === 1'b1 && run < 2000) begin
            @(negedge clk);
            run++;
        end
        total += run;
        n_vec++;
        if (total != 640 * NCH) begin
            n_err++;
            $display("FAIL timing_busy: start-to-idle %0d cycles, required %0d", total, 640 * NCH);
        end
        wait_idle("timing");
        en_period = 1;
    endtask

    task automatic test_multi_char();
        @(negedge clk);
        put(8'h10); put(8'h20); put(8'h30);
        bus_if.i_data_valid = 1'b0;
        n_vec++;
        if (o_count !== 5'd3 || o_checksum !== 8'h60) begin
            n_err++;
            $display("FAIL multi_load: count=%0d csum=0x%02h required 3/0x60", o_count, o_checksum);
        end
        send_frame("multi");
        bus_if.i_data       = 8'h99;
        bus_if.i_data_valid = 1'b1;
        bus_if.i_send       = 1'b1;
        @(negedge clk);
        bus_if.i_data_valid = 1'b0;
        bus_if.i_send       = 1'b0;
        n_vec++;
        if (o_busy !== 1'b1 || o_count !== 5'd3 || o_checksum !== 8'h60) begin
            n_err++;
            $display("FAIL multi_busy_hold: busy=%b count=%0d csum=0x%02h required 1/3/0x60", o_busy, o_count, o_checksum);
        end
        wait_idle("multi");
    endtask

    task automatic test_checksum_wrap();
        @(negedge clk);
        put(8'hFF); put(8'h02);
        bus_if.i_data_valid = 1'b0;
        n_vec++;
        if (o_checksum !== 8'h01) begin
            n_err++;
            $display("FAIL wrap_sum: csum=0x%02h required 0x01", o_checksum);
        end
        send_frame("wrap");
        wait_idle("wrap");
    endtask

    task automatic test_full();
        @(negedge clk);
        for (int i = 0; i < 16; i++) put(8'($urandom_range(0, 255)));
        bus_if.i_data_valid = 1'b0;
        n_vec++;
        if (o_count !== 5'd16 || bus_if.o_data_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_flag: count=%0d ready=%b required 16/0", o_count, bus_if.o_data_ready);
        end
        put(8'hEE);
        bus_if.i_data_valid = 1'b0;
        n_vec++;
        if (o_count !== 5'd16 || o_checksum !== m_sum) begin
            n_err++;
            $display("FAIL full_drop: count=%0d csum=0x%02h required 16/0x%02h", o_count, o_checksum, m_sum);
        end
        mon_chars = 0;
        send_frame("full");
        wait_idle("full");
        n_vec++;
        if (mon_chars != 15 + NCH) begin
            n_err++;
            $display("FAIL full_chars: %0d characters sent, required %0d", mon_chars, 15 + NCH);
        end
    endtask

    task automatic test_empty_send();
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        bus_if.i_send = 1'b1;
        @(negedge clk);
        bus_if.i_send = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_busy !== 1'b0 || o_tx !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL empty_send: busy/tx moved on empty commit, required busy=0 tx=1");
        end
        bus_if.i_data       = 8'hA5;
        bus_if.i_data_valid = 1'b1;
        exp_q.push_back(8'hA5);
        m_count = 1;
        m_sum   = 8'hA5;
        send_frame("valid_send");
        bus_if.i_data_valid = 1'b0;
        n_vec++;
        if (o_count !== 5'd1) begin
            n_err++;
            $display("FAIL valid_send_count: count=%0d required 1", o_count);
        end
        wait_idle("valid_send");
    endtask

    task automatic test_reset_mid_frame();
        int strobes;
        int cyc;
        en_period = 4;
        @(negedge clk);
        put(8'h3A); put(8'h81);
        bus_if.i_data_valid = 1'b0;
        send_frame("midrst");
        wait_tx_low("midrst");
        strobes = 0;
        cyc     = 0;
        while (strobes < 3 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            if (i_en) strobes++;
        end
        #2;
        n_vec++;
        if (o_tx !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_bit2: tx=%b during third data bit of 0x3A, required 0", o_tx);
        end
        rst_n = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_sum   = 8'h00;
        #1;
        n_vec++;
        if (o_tx !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_async: tx=%b right after reset, required 1", o_tx);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (o_busy !== 1'b0 || o_count !== 5'd0 || bus_if.o_data_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_state: busy=%b count=%0d ready=%b required 0/0/1", o_busy, o_count, bus_if.o_data_ready);
        end
        put(8'hC3);
        bus_if.i_data_valid = 1'b0;
        send_frame("after_rst");
        wait_idle("after_rst");
        en_period = 1;
    endtask

    initial begin
        rst_n               = 1'b0;
        bus_if.i_data       = 8'h00;
        bus_if.i_data_valid = 1'b0;
        bus_if.i_send       = 1'b0;
        test_reset();
        test_bit_timing();
        test_multi_char();
        test_checksum_wrap();
        test_full();
        test_empty_send();
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
